mmio_uart_port: RTL

- Memory-mapped I/O responder on the processor's data-memory bus (Address, WriteData, MemWrite, MemRead, ReadData).
- Decodes a 16-byte window and provides an 8N1 UART transmitter with a 1-entry holding buffer, a status register, a programmable baud divider and a 32-bit general-purpose output register that drives the processor's PortOut.
- Top level muxes ReadData onto the load path when Hit=1, in place of DataMemory.

---
 rtl/mmio_uart_port.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_port.sv
// Memory-mapped UART transmitter (8N1) with GPIO output register.
// Occupies a 16-byte window on the data-memory bus.
module mmio_uart_port #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter logic [15:0] CLKS_PER_BIT_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Tx,
  output logic [31:0] PortOut
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  txState_t    state;
  logic [7:0]  holdReg;
  logic        holdFull;
  logic        overrun;
  logic [15:0] baudDiv;
  logic [15:0] divLat;
  logic [15:0] bitCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic        txReg;
  logic [31:0] gpioReg;

  logic [1:0]  regSel;
  logic        wrEn;
  logic        wrTx;
  logic        wrStat;
  logic        wrBaud;
  logic        wrGpio;
  logic        bitEnd;
  logic        loadNow;
  logic        busy;
  logic        ovrSet;
  logic        ovrClr;
  logic [31:0] rdData;
  logic [1:0]  unusedAddr;

  assign unusedAddr = Address[1:0];

  assign Hit    = (Address[31:4] == BASE_ADDRESS[31:4]);
  assign regSel = Address[3:2];
  assign wrEn   = MemWrite & Hit;
  assign wrTx   = wrEn & (regSel == 2'd0);
  assign wrStat = wrEn & (regSel == 2'd1);
  assign wrBaud = wrEn & (regSel == 2'd2);
  assign wrGpio = wrEn & (regSel == 2'd3);

  assign busy    = (state != IDLE);
  assign bitEnd  = (bitCnt == 16'd0);
  assign loadNow = holdFull &
                   ((state == IDLE) |
                    ((state == STOP) & bitEnd));

  // A write that coincides with a transfer refills the freed slot.
  assign ovrSet = wrTx & holdFull & ~loadNow;
  assign ovrClr = wrStat & WriteData[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdReg  <= 8'd0;
      holdFull <= 1'b0;
      overrun  <= 1'b0;
      baudDiv  <= CLKS_PER_BIT_DEFAULT;
      gpioReg  <= 32'd0;
    end else begin
      if (loadNow) begin
        holdFull <= wrTx;
        if (wrTx) holdReg <= WriteData[7:0];
      end else if (wrTx && !holdFull) begin
        holdFull <= 1'b1;
        holdReg  <= WriteData[7:0];
      end
      if (ovrSet)      overrun <= 1'b1;
      else if (ovrClr) overrun <= 1'b0;
      if (wrBaud) begin
        if (WriteData[15:0] == 16'd0)
          baudDiv <= 16'd1;
        else
          baudDiv <= WriteData[15:0];
      end
      if (wrGpio) gpioReg <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      txReg    <= 1'b1;
      shiftReg <= 8'd0;
      divLat   <= 16'd0;
      bitCnt   <= 16'd0;
      bitIdx   <= 3'd0;
    end else if (loadNow) begin
      state    <= START;
      txReg    <= 1'b0;
      shiftReg <= holdReg;
      divLat   <= baudDiv;
      bitCnt   <= baudDiv - 16'd1;
      bitIdx   <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          txReg <= 1'b1;
        end
        START: begin
          if (bitEnd) begin
            state  <= DATA;
            bitIdx <= 3'd0;
            bitCnt <= divLat - 16'd1;
            txReg  <= shiftReg[0];
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitCnt   <= divLat - 16'd1;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              txReg <= 1'b1;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              txReg  <= shiftReg[1];
            end
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        STOP: begin
          if (bitEnd) state <= IDLE;
          else        bitCnt <= bitCnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdData = 32'd0;
    unique case (regSel)
      2'd0: rdData = 32'd0;
      2'd1: rdData = {29'd0, overrun, holdFull, busy};
      2'd2: rdData = {16'd0, baudDiv};
      2'd3: rdData = gpioReg;
      default: rdData = 32'd0;
    endcase
  end

  assign ReadData = (Hit && MemRead) ? rdData : 32'd0;
  assign Tx       = txReg;
  assign PortOut  = gpioReg;

endmodule
